// File: rtl/led_scan_pwm_if.sv
// Pin bundle for the LED scan/PWM driver: serial grey-data input, display timing controls and status.
interface led_scan_pwm_if #(
    parameter int unsigned CH   = 16,
    parameter int unsigned SCAN = 32
);
    localparam int unsigned RW = (SCAN > 1) ? $clog2(SCAN) : 1;

    logic          den;
    logic          dai;
    logic          gck_en;
    logic          vsync;
    logic [1:0]    mode;
    logic [CH-1:0] out;
    logic [RW-1:0] scan_row;
    logic          frame_ready;
    logic          err_ovf;

    modport master (
        output den, dai, gck_en, vsync, mode,
        input  out, scan_row, frame_ready, err_ovf
    );

    modport slave (
        input  den, dai, gck_en, vsync, mode,
        output out, scan_row, frame_ready, err_ovf
    );
endinterface

// File: rtl/led_scan_pwm.sv
// Double-banked LED frame buffer with a serial loader and a row-scanned, subframe-split PWM output.
module led_scan_pwm #(
    parameter int unsigned CH   = 16,
    parameter int unsigned SCAN = 32,
    parameter int unsigned GW   = 16
) (
    input logic          clk,
    input logic          rst,
    led_scan_pwm_if.slave bus
);
    localparam int unsigned N  = CH * SCAN;
    localparam int unsigned AW = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned WW = $clog2(N + 1);
    localparam int unsigned BW = (GW > 1) ? $clog2(GW) : 1;
    localparam int unsigned RW = (SCAN > 1) ? $clog2(SCAN) : 1;

    logic [GW-1:0] mem [2][N];

    logic          wbank;
    logic [BW-1:0] bcnt;
    logic [GW-1:0] shreg;
    logic [WW-1:0] waddr;
    logic          frame_ready;
    logic          err_ovf;
    logic          vs_q;
    logic [1:0]    s_lat;

    logic [GW-1:0] tick;
    logic [RW-1:0] row;
    logic [1:0]    sub;
    logic [GW-1:0] cnt [CH];
    logic [CH-1:0] out_q;
    logic [RW-1:0] scan_row_q;

    logic          vs_rise;
    logic          word_done;
    logic          full;
    logic          swap;
    logic [GW-1:0] word;
    logic [GW-1:0] last_tick;
    logic [1:0]    rem_mask;
    logic [AW-1:0] rd_base;
    logic [GW-1:0] rd_word [CH];
    logic [GW-1:0] on [CH];
    logic [GW-1:0] cnt_n [CH];
    logic [CH-1:0] out_n;

    assign vs_rise   = bus.vsync & ~vs_q;
    assign word_done = bus.den && (bcnt == BW'(GW - 1));
    assign word      = {bus.dai, shreg[GW-2:0]};
    assign full      = (waddr == WW'(N));
    // A last word landing on the sync edge completes the frame in time to swap.
    assign swap      = vs_rise && (frame_ready || (word_done && (waddr == WW'(N - 1))));
    assign last_tick = {GW{1'b1}} >> s_lat;

    // 2^S - 1: both the remainder mask and the last subframe index
    always_comb begin
        rem_mask = 2'b11;
        case (s_lat)
            2'd0:    rem_mask = 2'b00;
            2'd1:    rem_mask = 2'b01;
            default: rem_mask = 2'b11;
        endcase
    end

    // Frame buffer: no reset, contents survive rst
    always_ff @(posedge clk) begin
        if (!rst && word_done && !full)
            mem[wbank][AW'(waddr)] <= word;
    end

    // Serial capture, bank swap and mode latch
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wbank       <= 1'b0;
            bcnt        <= '0;
            shreg       <= '0;
            waddr       <= '0;
            frame_ready <= 1'b0;
            err_ovf     <= 1'b0;
            vs_q        <= 1'b0;
            s_lat       <= 2'd0;
        end else begin
            vs_q <= bus.vsync;
            if (bus.den) begin
                shreg[bcnt] <= bus.dai;
                bcnt        <= word_done ? '0 : bcnt + BW'(1);
            end else begin
                bcnt <= '0;
            end
            if (swap) begin
                wbank       <= ~wbank;
                waddr       <= '0;
                frame_ready <= 1'b0;
                err_ovf     <= 1'b0;
            end else if (word_done) begin
                if (full) begin
                    err_ovf <= 1'b1;
                end else begin
                    waddr <= waddr + WW'(1);
                    if (waddr == WW'(N - 1))
                        frame_ready <= 1'b1;
                end
            end
            if (vs_rise)
                s_lat <= (bus.mode == 2'd0) ? 2'd0 : (bus.mode == 2'd1) ? 2'd1 : 2'd2;
        end
    end

    // Per-channel on-time for the current row/subframe; remainder spread over early subframes
    always_comb begin
        rd_base = AW'(row) * AW'(CH);
        for (int c = 0; c < CH; c++) begin
            rd_word[c] = mem[~wbank][rd_base + AW'(c)];
            on[c]      = (rd_word[c] >> s_lat) + GW'(sub < (rd_word[c][1:0] & rem_mask));
        end
    end

    always_comb begin
        out_n = '0;
        for (int c = 0; c < CH; c++) begin
            cnt_n[c] = cnt[c];
            if (!bus.vsync)
                cnt_n[c] = '0;
            else if (bus.gck_en) begin
                if (tick == '0)
                    cnt_n[c] = on[c];
                else if (cnt[c] != '0)
                    cnt_n[c] = cnt[c] - GW'(1);
            end
            out_n[c] = (cnt_n[c] != '0);
        end
    end

    // Display sequencer: tick within row, row within subframe, subframe within frame
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick       <= '0;
            row        <= '0;
            sub        <= 2'd0;
            scan_row_q <= '0;
            out_q      <= '0;
            for (int c = 0; c < CH; c++) cnt[c] <= '0;
        end else begin
            for (int c = 0; c < CH; c++) cnt[c] <= cnt_n[c];
            out_q <= out_n;
            if (!bus.vsync) begin
                tick <= '0;
                row  <= '0;
                sub  <= 2'd0;
            end else if (bus.gck_en) begin
                if (tick == '0)
                    scan_row_q <= row;
                if (tick == last_tick) begin
                    tick <= '0;
                    if (row == RW'(SCAN - 1)) begin
                        row <= '0;
                        sub <= (sub == rem_mask) ? 2'd0 : sub + 2'd1;
                    end else begin
                        row <= row + RW'(1);
                    end
                end else begin
                    tick <= tick + GW'(1);
                end
            end
        end
    end

    assign bus.out         = out_q;
    assign bus.scan_row    = scan_row_q;
    assign bus.frame_ready = frame_ready;
    assign bus.err_ovf     = err_ovf;
endmodule

// File: doc/led_scan_pwm.md
LED_SCAN_PWM -- requirements
Module: led_scan_pwm

Interface
REQ-001 Parameter CH, default 16, number of PWM output channels (columns).
REQ-002 Parameter SCAN, default 32, number of scan lines (rows) per frame.
REQ-003 Parameter GW, default 16, grey-level width in bits; one word = GW bits.
REQ-004 clk  input  1  single system clock; all state is updated on its rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 den  input  1  serial data enable.
REQ-007 dai  input  1  serial grey data, sampled when den=1.
REQ-008 gck_en  input  1  grey-clock tick strobe, one clk wide.
REQ-009 vsync  input  1  display enable / frame sync.
REQ-010 mode  input  2  PWM split: 0 = 1 subframe, 1 = 2 subframes, 2 or 3 = 4 subframes.
REQ-011 out  output  CH  channel drive, bit c = column c.
REQ-012 scan_row  output  clog2(SCAN)  active row index.
REQ-013 frame_ready  output  1  a complete frame is in the write bank, awaiting swap.
REQ-014 err_ovf  output  1  sticky: a word arrived after the write bank was full.

Function
REQ-015 The frame buffer SHALL be two banks (write, display) of CH*SCAN words, with one full row of CH words readable in a single cycle.
REQ-016 Input: each clk with den=1 SHALL shift dai into word bit position bcnt, LSB first; on bit GW-1 the word SHALL be written to write-bank address waddr, and then waddr increments and bcnt clears.
REQ-017 Address order SHALL be waddr = row*CH + column.
REQ-018 den=0 SHALL clear bcnt and discard any partial word; waddr SHALL hold.
REQ-019 When waddr reaches CH*SCAN, frame_ready SHALL go 1 and further complete words SHALL be dropped, setting err_ovf.
REQ-020 A vsync 0->1 transition SHALL be detected with a one-clk registered edge.
REQ-021 On that edge with frame_ready=1, the banks SHALL swap, waddr SHALL go to 0, and frame_ready and err_ovf SHALL clear.
REQ-022 On that edge with frame_ready=0, the banks SHALL NOT swap and the write state SHALL be kept.
REQ-023 The effective mode S (0, 1 or 2) SHALL be latched only on the vsync rising edge; mode changes mid-frame are ignored.
REQ-024 Row period: L = 2^GW >> S gck_en ticks; a frame is 2^S subframes, each visiting rows 0..SCAN-1 in order.
REQ-025 The display sequencer (tick, row, subframe) SHALL advance only on gck_en while vsync=1.
REQ-026 At the end of the last row of the last subframe, the sequencer SHALL wrap to row 0, subframe 0.
REQ-027 On the first tick of each row, each channel counter SHALL load on = (v >> S) + (k < (v mod 2^S) ? 1 : 0), where v is the display-bank word and k is the subframe index.
REQ-028 The sum of on over all subframes SHALL equal v exactly.
REQ-029 Each later gck_en tick SHALL decrement every nonzero counter; counters SHALL saturate at 0.
REQ-030 out[c] SHALL equal vsync AND (counter c != 0).
REQ-031 Output timing: value v, S=0, gives exactly v high ticks starting the clk after the load tick.
REQ-032 Boundary: v=0 SHALL keep the channel low for the whole row.
REQ-033 Boundary: v = 2^GW-1 with S=0 SHALL leave the channel low on the final tick of the row.
REQ-034 scan_row SHALL update on the load tick and hold for the whole row.
REQ-035 vsync=0 SHALL force out to 0, clear all counters, and reset the sequencer to row 0, subframe 0, tick 0.
REQ-036 Input capture SHALL continue while vsync=0.
REQ-037 Input and display SHALL run concurrently; writes SHALL never alter the display bank.
REQ-038 If den capture completes the last word in the same clk as the vsync rising edge, the word SHALL be written and the swap SHALL occur in that clk.

Reset
REQ-039 rst=1 SHALL immediately force out=0, scan_row=0, frame_ready=0, err_ovf=0, and bcnt=waddr=0.
REQ-040 rst=1 SHALL also clear all counters and the sequencer and set S=0.
REQ-041 Frame buffer contents SHALL be unaffected by rst and undefined after power-up.
REQ-042 Reset asserted mid-word or mid-row SHALL abandon that operation with no partial write.

Verification (CH=4, SCAN=2, GW=4)
REQ-043 Reset: assert rst during display -> out=0000, scan_row=0, frame_ready=0, err_ovf=0 in the same cycle.
REQ-044 Load 8 words of value 5, raise vsync, mode=0 -> swap; each out bit is high 5 ticks of each 16-tick row, and scan_row alternates 0,1.
REQ-045 mode=1, all words 7 -> L=8; subframe 0 gives 4 high ticks, subframe 1 gives 3 high ticks, for 7 in total.
REQ-046 mode=2, word 6 -> on per subframe = 2,2,1,1.
REQ-047 Drop den after 2 bits, then send a full word -> the word is stored at the same waddr with no partial data.
REQ-048 Send a 9th word -> err_ovf=1 and the write bank is unchanged.
REQ-049 Overlap: load a new frame while displaying -> the displayed values change only after the next vsync rising edge.
